kpn_add_process: RTL and testbench

KPN process node that sits directly downstream of the precharged queue stages. It consumes one token from each of two input FIFOs (A, then B) using Kahn blocking-read semantics, adds them, and emits the sum into an output FIFO using blocking-write semantics. It is the first compute process in the network. It provides the read handshake the queue stages need so they no longer free-run.

---
 rtl/kpn_add_process_if.sv | 28 ++
 rtl/kpn_add_process.sv | 77 +++++++
 tb/tb_kpn_add_process.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/kpn_add_process_if.sv
// Token handshake bundle between the add process and its two input FIFOs and output FIFO.
// master = process side, slave = FIFO/environment side.
interface kpn_add_process_if #(
  parameter int BITS_NUMBER = 16,
  parameter int COUNT_BITS  = 16
);
  logic [BITS_NUMBER-1:0] data_in_a;
  logic                   empty_a;
  logic                   rd_a;
  logic [BITS_NUMBER-1:0] data_in_b;
  logic                   empty_b;
  logic                   rd_b;
  logic                   full;
  logic                   wr;
  logic [BITS_NUMBER-1:0] data_out;
  logic                   carry;
  logic [COUNT_BITS-1:0]  token_count;

  modport master (
    input  data_in_a, empty_a, data_in_b, empty_b, full,
    output rd_a, rd_b, wr, data_out, carry, token_count
  );

  modport slave (
    output data_in_a, empty_a, data_in_b, empty_b, full,
    input  rd_a, rd_b, wr, data_out, carry, token_count
  );
endinterface

// File: rtl/kpn_add_process.sv
// Kahn process: blocking-read one token from A, then B, add them, blocking-write the sum.
// state  | meaning
// READ_A | waiting to pop a token from FIFO A
// READ_B | A held in a_reg, waiting to pop a token from FIFO B
// WRITE  | sum registered, waiting for room in the output FIFO
module kpn_add_process #(
  parameter int BITS_NUMBER = 16,
  parameter int COUNT_BITS  = 16
) (
  input  logic               clk,
  input  logic               reset,
  kpn_add_process_if.master  bus
);
  localparam logic [1:0] READ_A = 2'd0;
  localparam logic [1:0] READ_B = 2'd1;
  localparam logic [1:0] WRITE  = 2'd2;

  logic [1:0]             state;
  logic [BITS_NUMBER-1:0] a_reg;
  logic [BITS_NUMBER-1:0] data_q;
  logic                   carry_q;
  logic [COUNT_BITS-1:0]  count_q;
  logic [BITS_NUMBER:0]   sum;
  logic                   rd_a;
  logic                   rd_b;
  logic                   wr;

  assign sum = {1'b0, a_reg} + {1'b0, bus.data_in_b};

  // Strobes are forced low during reset so a FIFO never pops while state is being cleared.
  always_comb begin
    rd_a = 1'b0;
    rd_b = 1'b0;
    wr   = 1'b0;
    if (!reset) begin
      case (state)
        READ_A:  rd_a = !bus.empty_a;
        READ_B:  rd_b = !bus.empty_b;
        WRITE:   wr   = !bus.full;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= READ_A;
      a_reg   <= '0;
      data_q  <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
    end else begin
      case (state)
        READ_A: if (rd_a) begin
          a_reg <= bus.data_in_a;
          state <= READ_B;
        end
        READ_B: if (rd_b) begin
          {carry_q, data_q} <= sum;
          state             <= WRITE;
        end
        WRITE: if (wr) begin
          count_q <= count_q + COUNT_BITS'(1);
          state   <= READ_A;
        end
        default: state <= READ_A;
      endcase
    end
  end

  assign bus.rd_a        = rd_a;
  assign bus.rd_b        = rd_b;
  assign bus.wr          = wr;
  assign bus.data_out    = data_q;
  assign bus.carry       = carry_q;
  assign bus.token_count = count_q;
endmodule

// File: tb/tb_kpn_add_process.sv
// Bench for kpn_add_process: FIFO models feed tokens, a scoreboard queue holds expected sums,
// and an independent monitor checks every output write against it.
module tb_kpn_add_process;
  typedef struct packed {
    logic [15:0] sum;
    logic        carry;
    logic [15:0] idx;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] fa[$];
  logic [15:0] fb[$];
  exp_t        exp_q[$];
  logic [15:0] exp_idx = 16'd0;

  bit   rand_en = 1'b0;
  bit   force_empty_b = 1'b0;
  bit   force_full = 1'b0;
  logic sa, sb, sw;

  kpn_add_process_if #(.BITS_NUMBER(16), .COUNT_BITS(16)) bus ();

  kpn_add_process #(.BITS_NUMBER(16), .COUNT_BITS(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    exp_t e;
    s = {1'b0, a} + {1'b0, b};
    e.sum = s[15:0];
    e.carry = s[16];
    e.idx = exp_idx;
    exp_idx = exp_idx + 16'd1;
    fa.push_back(a);
    fb.push_back(b);
    exp_q.push_back(e);
  endtask

  task automatic drive();
    bus.empty_a   = (fa.size() == 0) || (rand_en && $urandom_range(0, 3) == 0);
    bus.data_in_a = (fa.size() > 0) ? fa[0] : 16'($urandom);
    bus.empty_b   = force_empty_b || (fb.size() == 0) || (rand_en && $urandom_range(0, 3) == 0);
    bus.data_in_b = (fb.size() > 0) ? fb[0] : 16'($urandom);
    bus.full      = force_full || (rand_en && $urandom_range(0, 2) == 0);
  endtask

  // One clock: capture strobes mid-cycle, let the FIFO models pop on the edge, then re-drive.
  task automatic step();
    @(negedge clk);
    sa = bus.rd_a;
    sb = bus.rd_b;
    sw = bus.wr;
    @(posedge clk);
    if (sa && fa.size() > 0) void'(fa.pop_front());
    if (sb && fb.size() > 0) void'(fb.pop_front());
    #1 drive();
  endtask

  task automatic run_until_empty(input string name, input int limit);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < limit) begin
      step();
      n++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      check("one_strobe", 32'($countones({bus.rd_a, bus.rd_b, bus.wr}) <= 1), 32'd1);
      if (bus.wr) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wr", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("data_out", 32'(bus.data_out), 32'(e.sum));
          check("carry", 32'(bus.carry), 32'(e.carry));
          check("token_count_at_wr", 32'(bus.token_count), 32'(e.idx));
        end
      end
    end
  end

  initial begin
    int n_a, n_b, n_w;
    logic [15:0] cnt0;
    bus.empty_a = 1'b0;
    bus.empty_b = 1'b0;
    bus.full = 1'b0;
    bus.data_in_a = 16'h1234;
    bus.data_in_b = 16'h5678;
    repeat (3) @(posedge clk);
    #2;
    check("rst_rd_a", 32'(bus.rd_a), 32'd0);
    check("rst_rd_b", 32'(bus.rd_b), 32'd0);
    check("rst_wr", 32'(bus.wr), 32'd0);
    check("rst_data_out", 32'(bus.data_out), 32'd0);
    check("rst_carry", 32'(bus.carry), 32'd0);
    check("rst_count", 32'(bus.token_count), 32'd0);

    // basic sum with exact strobe timing
    @(posedge clk);
    #1 reset = 1'b0;
    push_pair(16'h0003, 16'h0004);
    drive();
    step(); check("basic_c1", 32'({sa, sb, sw}), 32'b100);
    step(); check("basic_c2", 32'({sa, sb, sw}), 32'b010);
    check("basic_data_early", 32'(bus.data_out), 32'h0007);
    step(); check("basic_c3", 32'({sa, sb, sw}), 32'b001);
    check("basic_count", 32'(bus.token_count), 32'd1);

    // overflow
    push_pair(16'hFFFF, 16'h0002);
    drive();
    run_until_empty("overflow", 20);
    check("overflow_count", 32'(bus.token_count), 32'd2);

    // blocking read on B
    push_pair(16'h0005, 16'h0010);
    force_empty_b = 1'b1;
    drive();
    step(); check("blkrd_rd_a", 32'({sa, sb, sw}), 32'b100);
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
        step();
        if (sa || sb || sw) bad++;
      end
      check("blkrd_idle", 32'(bad), 32'd0);
    end
    force_empty_b = 1'b0;
    drive();
    run_until_empty("blkrd", 20);

    // blocking write
    push_pair(16'h0001, 16'h0002);
    push_pair(16'h0009, 16'h0009);
    force_full = 1'b1;
    drive();
    step(); step();
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
        step();
        if (sa || sw || bus.data_out !== 16'h0003) bad++;
      end
      check("blkwr_hold", 32'(bad), 32'd0);
    end
    force_full = 1'b0;
    drive();
    step(); check("blkwr_wr", 32'({sa, sb, sw}), 32'b001);
    step(); check("blkwr_next_rd_a", 32'({sa, sb, sw}), 32'b100);
    run_until_empty("blkwr", 20);

    // streaming at full rate
    cnt0 = bus.token_count;
    for (int i = 1; i <= 8; i++) push_pair(16'(i), 16'(10 * i));
    drive();
    n_a = 0; n_b = 0; n_w = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      n_a += int'(sa); n_b += int'(sb); n_w += int'(sw);
    end
    check("stream_rd_a", 32'(n_a), 32'd8);
    check("stream_rd_b", 32'(n_b), 32'd8);
    check("stream_wr", 32'(n_w), 32'd8);
    check("stream_count", 32'(bus.token_count), 32'(cnt0 + 16'd8));
    check("stream_drained", 32'(exp_q.size()), 32'd0);

    // random traffic with stalls on every side
    rand_en = 1'b1;
    for (int i = 0; i < 200; i++) push_pair(16'($urandom), 16'($urandom));
    drive();
    run_until_empty("random", 8000);
    rand_en = 1'b0;

    // reset mid-operation with A popped and B pending
    fa.push_back(16'h0007);
    drive();
    step(); check("mid_rd_a", 32'({sa, sb, sw}), 32'b100);
    step();
    #2 reset = 1'b1;
    #1;
    check("mid_strobes", 32'({bus.rd_a, bus.rd_b, bus.wr}), 32'b000);
    check("mid_data_out", 32'(bus.data_out), 32'd0);
    check("mid_carry", 32'(bus.carry), 32'd0);
    check("mid_count", 32'(bus.token_count), 32'd0);
    fa.delete();
    fb.delete();
    exp_q.delete();
    exp_idx = 16'd0;
    @(posedge clk);
    #1 reset = 1'b0;
    push_pair(16'h0002, 16'h0003);
    drive();
    run_until_empty("post_reset", 20);
    check("post_reset_data", 32'(bus.data_out), 32'h0005);
    check("post_reset_count", 32'(bus.token_count), 32'd1);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
